// File: rtl/uart_cmd_ctrl.sv
// UART command controller: A5 + challenge bytes -> one PUF run -> 5A header and response bytes, else an error byte.
// Replies start one cycle after the decision; transmit holds each byte until the UART's tx_busy handshake completes.
module uart_cmd_ctrl #(
  parameter int DATA_BITS      = 8,
  parameter int CHAL_BYTES     = 8,
  parameter int RESP_BYTES     = 4,
  parameter int TIMEOUT_CYCLES = 5_000_000
) (
  input  logic                             clk,
  input  logic                             areset,
  input  logic                             rx_valid,
  input  logic [DATA_BITS-1:0]             data_in,
  output logic                             rx_enable,
  output logic [DATA_BITS-1:0]             data_out,
  output logic                             tx_enable,
  input  logic                             tx_busy,
  output logic [CHAL_BYTES*DATA_BITS-1:0]  challenge,
  output logic                             puf_start,
  input  logic                             puf_done,
  input  logic [RESP_BYTES*DATA_BITS-1:0]  response,
  output logic                             busy
);

  localparam int MAX_BYTES = (CHAL_BYTES > RESP_BYTES + 1) ? CHAL_BYTES : RESP_BYTES + 1;
  localparam int CW        = $clog2(MAX_BYTES + 1);
  localparam int TW        = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [DATA_BITS-1:0] CMD_CHAL = DATA_BITS'(8'hA5);
  localparam logic [DATA_BITS-1:0] RESP_HDR = DATA_BITS'(8'h5A);
  localparam logic [DATA_BITS-1:0] ERR_CMD  = DATA_BITS'(8'hEE);
  localparam logic [DATA_BITS-1:0] ERR_TMO  = DATA_BITS'(8'hEF);

  typedef enum logic [2:0] {
    IDLE,
    RX_CHAL,
    START,
    WAIT_PUF,
    TX_LOAD,
    TX_WAIT_HI,
    TX_WAIT_LO
  } state_e;

  state_e                          state_q, state_d;
  logic [CW-1:0]                   idx_q, idx_d;
  logic [CW-1:0]                   qptr_q, qptr_d;
  logic [CW-1:0]                   qlen_q, qlen_d;
  logic [TW-1:0]                   tmo_q, tmo_d;
  logic [DATA_BITS-1:0]            hdr_q, hdr_d;
  logic [RESP_BYTES*DATA_BITS-1:0] resp_q, resp_d;
  logic [CHAL_BYTES*DATA_BITS-1:0] chal_q, chal_d;
  logic [DATA_BITS-1:0]            dout_q, dout_d;
  logic                            txen_q, txen_d;

  logic [TW-1:0]        tmo_inc;
  logic                 tmo_hit;
  logic [DATA_BITS-1:0] cur_byte;
  int                   byte_sel;

  assign tmo_inc = (tmo_q == TW'(TIMEOUT_CYCLES)) ? tmo_q : tmo_q + TW'(1);
  assign tmo_hit = (tmo_q >= TW'(TIMEOUT_CYCLES - 1));

  // Queue slot 0 is the header/error byte; slots 1.. map to response bytes, LSB first.
  always_comb begin
    byte_sel = 0;
    cur_byte = hdr_q;
    if (qptr_q != '0) begin
      byte_sel = int'(qptr_q) - 1;
      cur_byte = resp_q[byte_sel*DATA_BITS +: DATA_BITS];
    end
  end

  always_ff @(posedge clk) begin
    if (areset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      qptr_q  <= '0;
      qlen_q  <= '0;
      tmo_q   <= '0;
      hdr_q   <= '0;
      resp_q  <= '0;
      chal_q  <= '0;
      dout_q  <= '0;
      txen_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      qptr_q  <= qptr_d;
      qlen_q  <= qlen_d;
      tmo_q   <= tmo_d;
      hdr_q   <= hdr_d;
      resp_q  <= resp_d;
      chal_q  <= chal_d;
      dout_q  <= dout_d;
      txen_q  <= txen_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    qptr_d  = qptr_q;
    qlen_d  = qlen_q;
    tmo_d   = tmo_q;
    hdr_d   = hdr_q;
    resp_d  = resp_q;
    chal_d  = chal_q;
    dout_d  = dout_q;
    txen_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (rx_valid) begin
          if (data_in == CMD_CHAL) begin
            state_d = RX_CHAL;
            idx_d   = '0;
            tmo_d   = '0;
          end else begin
            hdr_d   = ERR_CMD;
            qlen_d  = CW'(1);
            qptr_d  = '0;
            state_d = TX_LOAD;
          end
        end
      end
      RX_CHAL: begin
        if (rx_valid) begin
          chal_d[int'(idx_q)*DATA_BITS +: DATA_BITS] = data_in;
          idx_d = idx_q + CW'(1);
          tmo_d = '0;
          if (idx_q == CW'(CHAL_BYTES - 1)) state_d = START;
        end else begin
          tmo_d = tmo_inc;
          if (tmo_hit) state_d = IDLE;
        end
      end
      START: begin
        state_d = WAIT_PUF;
        tmo_d   = '0;
      end
      WAIT_PUF: begin
        if (puf_done) begin
          resp_d  = response;
          hdr_d   = RESP_HDR;
          qlen_d  = CW'(RESP_BYTES + 1);
          qptr_d  = '0;
          state_d = TX_LOAD;
        end else if (tmo_hit) begin
          tmo_d   = tmo_inc;
          hdr_d   = ERR_TMO;
          qlen_d  = CW'(1);
          qptr_d  = '0;
          state_d = TX_LOAD;
        end else begin
          tmo_d = tmo_inc;
        end
      end
      TX_LOAD: begin
        if (!tx_busy) begin
          dout_d  = cur_byte;
          txen_d  = 1'b1;
          state_d = TX_WAIT_HI;
        end
      end
      TX_WAIT_HI: begin
        if (tx_busy) state_d = TX_WAIT_LO;
      end
      TX_WAIT_LO: begin
        if (!tx_busy) begin
          if (qptr_q == qlen_q - CW'(1)) begin
            qptr_d  = '0;
            state_d = IDLE;
          end else begin
            qptr_d  = qptr_q + CW'(1);
            state_d = TX_LOAD;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rx_enable = (state_q == IDLE) || (state_q == RX_CHAL);
    busy      = (state_q != IDLE);
    puf_start = (state_q == START);
  end

  assign tx_enable = txen_q;
  assign data_out  = dout_q;
  assign challenge = chal_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Bench for uart_cmd_ctrl with a small UART/PUF model and a queue of expected transmit bytes.
module tb_uart_cmd_ctrl;

  logic        clk = 1'b0;
  logic        areset = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  data_in = 8'h00;
  logic        rx_enable;
  logic [7:0]  data_out;
  logic        tx_enable;
  logic        tx_busy = 1'b0;
  logic [15:0] challenge;
  logic        puf_start;
  logic        puf_done = 1'b0;
  logic [15:0] response = 16'h0000;
  logic        busy;

  int n_checks = 0;
  int n_fail = 0;
  int txen_cnt = 0;
  int pst_cnt = 0;
  int unexp_cnt = 0;
  int busy_len = 3;
  int rst_epoch = 0;
  int tx_base = 0;
  int pst_base = 0;
  logic [7:0] exp_q[$];

  logic [7:0] m_byte;
  int         m_ep;
  bit         m_stable;

  uart_cmd_ctrl #(
    .DATA_BITS(8), .CHAL_BYTES(2), .RESP_BYTES(2), .TIMEOUT_CYCLES(100)
  ) dut (
    .clk(clk), .areset(areset), .rx_valid(rx_valid), .data_in(data_in),
    .rx_enable(rx_enable), .data_out(data_out), .tx_enable(tx_enable),
    .tx_busy(tx_busy), .challenge(challenge), .puf_start(puf_start),
    .puf_done(puf_done), .response(response), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tx_enable) txen_cnt++;
    if (puf_start) pst_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    data_in  = b;
    tick();
    rx_valid = 1'b0;
    tick();
  endtask

  task automatic begin_test();
    tx_base  = txen_cnt;
    pst_base = pst_cnt;
  endtask

  task automatic end_test(input int n_tx, input int n_pst);
    chk("tx_count", txen_cnt - tx_base, n_tx);
    chk("puf_start_count", pst_cnt - pst_base, n_pst);
    chk("exp_left", exp_q.size(), 0);
    chk("unexpected_tx", unexp_cnt, 0);
  endtask

  task automatic wait_puf();
    for (int i = 0; i < 30; i++) begin
      if (pst_cnt != pst_base) break;
      tick();
    end
    chk("puf_start_seen", pst_cnt - pst_base, 1);
  endtask

  task automatic pulse_done(input logic [15:0] r);
    response = r;
    puf_done = 1'b1;
    tick();
    puf_done = 1'b0;
    response = 16'h0000;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (!busy) break;
      tick();
    end
    chk(tag, busy, 0);
  endtask

  // UART model: scoreboard pop on each send request, then hold tx_busy for busy_len cycles.
  initial begin
    forever begin
      @(negedge clk);
      if (tx_enable) begin
        chk("tx_while_busy", tx_busy, 0);
        if (exp_q.size() == 0) unexp_cnt++;
        else chk("tx_byte", data_out, exp_q.pop_front());
        m_byte   = data_out;
        m_ep     = rst_epoch;
        m_stable = 1'b1;
        @(posedge clk);
        #1 tx_busy = 1'b1;
        repeat (busy_len) begin
          @(negedge clk);
          if (rst_epoch == m_ep && data_out !== m_byte) m_stable = 1'b0;
        end
        @(posedge clk);
        #1 tx_busy = 1'b0;
        @(negedge clk);
        if (rst_epoch == m_ep && data_out !== m_byte) m_stable = 1'b0;
        if (rst_epoch == m_ep) chk("dout_stable", m_stable, 1);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) tick();
    areset = 1'b0;
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_rx_enable", rx_enable, 1);
    chk("rst_tx_enable", tx_enable, 0);
    chk("rst_puf_start", puf_start, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_challenge", challenge, 0);

    // Full command, normal reply
    begin_test();
    exp_q.push_back(8'h5A); exp_q.push_back(8'hEF); exp_q.push_back(8'hBE);
    send(8'hA5); send(8'h11); send(8'h22);
    wait_puf();
    chk("t1_challenge", challenge, 16'h2211);
    chk("t1_rx_enable_off", rx_enable, 0);
    pulse_done(16'hBEEF);
    wait_idle("t1_idle", 500);
    end_test(3, 1);

    // Bad command byte
    begin_test();
    exp_q.push_back(8'hEE);
    send(8'h3C);
    wait_idle("t2_idle", 200);
    end_test(1, 0);

    // Inter-byte timeout leaves a partial challenge
    begin_test();
    send(8'hA5); send(8'h99);
    repeat (90) tick();
    chk("t3_still_busy", busy, 1);
    repeat (20) tick();
    chk("t3_idle", busy, 0);
    chk("t3_challenge", challenge, 16'h2299);
    end_test(0, 0);

    // PUF timeout
    begin_test();
    exp_q.push_back(8'hEF);
    send(8'hA5); send(8'h33); send(8'h44);
    wait_puf();
    chk("t4_challenge", challenge, 16'h4433);
    repeat (90) tick();
    chk("t4_no_tx_yet", txen_cnt - tx_base, 0);
    wait_idle("t4_idle", 300);
    end_test(1, 1);

    // Slow UART
    busy_len = 50;
    begin_test();
    exp_q.push_back(8'h5A); exp_q.push_back(8'h34); exp_q.push_back(8'h12);
    send(8'hA5); send(8'h55); send(8'h66);
    wait_puf();
    pulse_done(16'h1234);
    wait_idle("t5_idle", 1000);
    chk("t5_challenge", challenge, 16'h6655);
    end_test(3, 1);

    // Reset in the middle of the reply
    busy_len = 10;
    begin_test();
    exp_q.push_back(8'h5A); exp_q.push_back(8'hFE); exp_q.push_back(8'hCA);
    send(8'hA5); send(8'h77); send(8'h88);
    wait_puf();
    pulse_done(16'hCAFE);
    for (int i = 0; i < 500; i++) begin
      if (txen_cnt - tx_base >= 2) break;
      tick();
    end
    chk("t6_two_sent", txen_cnt - tx_base, 2);
    repeat (3) tick();
    areset = 1'b1;
    rst_epoch++;
    tick();
    areset = 1'b0;
    exp_q.delete();
    chk("t6_busy_after_rst", busy, 0);
    chk("t6_dout_after_rst", data_out, 0);
    chk("t6_chal_after_rst", challenge, 0);
    chk("t6_rx_enable_after_rst", rx_enable, 1);
    repeat (100) tick();
    end_test(2, 1);

    begin_test();
    exp_q.push_back(8'h5A); exp_q.push_back(8'hCD); exp_q.push_back(8'hAB);
    send(8'hA5); send(8'h01); send(8'h02);
    wait_puf();
    pulse_done(16'hABCD);
    wait_idle("t7_idle", 500);
    chk("t7_challenge", challenge, 16'h0201);
    end_test(3, 1);

    repeat (5) tick();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
